// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-table sequencer: one IIC write per table entry after power-up settle.
// Define CFG_READBACK_EN to read back and compare every register after it is written.
module ov5640_cfg_seq #(
    parameter int         REG_NUM  = 252,
    parameter int         IDX_W    = 10,
    parameter logic [7:0] DEV_ADDR = 8'h78,
    parameter int         DLY_CYC  = 50000,
    parameter int         TMO_CYC  = 4096
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             power_done,
    input  logic             cfg_restart,
    output logic [IDX_W-1:0] tab_index,
    input  logic [23:0]      tab_data,
    output logic             iic_start,
    output logic [31:0]      iic_wdata,
    input  logic             iic_busy,
    input  logic [7:0]       iic_rdata,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int DLY_W = $clog2(DLY_CYC + 1);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [7:0] DEV_RD = DEV_ADDR | 8'h01;

    typedef enum logic [3:0] {
        S_IDLE, S_DLY, S_FETCH, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_DONE, S_ERR
`ifdef CFG_READBACK_EN
        , S_RD_ISSUE, S_RD_HI, S_RD_LO, S_CHECK
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [DLY_W-1:0] dly_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [31:0]      wdata_q;
    logic             dly_last, tmo_last, idx_last;

    assign dly_last = (dly_cnt >= DLY_W'(DLY_CYC - 1));
    assign tmo_last = (tmo_cnt >= TMO_W'(TMO_CYC - 1));
    assign idx_last = (tab_index == IDX_W'(REG_NUM - 1));

`ifdef CFG_READBACK_EN
    logic [7:0] val_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^iic_rdata;
`endif

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // A new transfer is only started once the master is idle, which covers a
    // transfer left in flight by an earlier power drop.
    always_comb begin
        state_nxt = state;
        iic_start = 1'b0;
        iic_wdata = wdata_q;
        if (state != S_IDLE && !power_done) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (power_done) state_nxt = S_DLY;
                S_DLY:     if (dly_last) state_nxt = S_FETCH;
                S_FETCH:   state_nxt = S_ISSUE;
                S_ISSUE: begin
                    if (!iic_busy) begin
                        iic_start = 1'b1;
                        iic_wdata = {DEV_ADDR, tab_data};
                        state_nxt = S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (iic_busy)      state_nxt = S_WAIT_LO;
                    else if (tmo_last) state_nxt = S_ERR;
                end
`ifdef CFG_READBACK_EN
                S_WAIT_LO: if (!iic_busy) state_nxt = S_RD_ISSUE;
                S_RD_ISSUE: begin
                    if (!iic_busy) begin
                        iic_start = 1'b1;
                        iic_wdata = {DEV_RD, wdata_q[23:8], 8'h00};
                        state_nxt = S_RD_HI;
                    end
                end
                S_RD_HI: begin
                    if (iic_busy)      state_nxt = S_RD_LO;
                    else if (tmo_last) state_nxt = S_ERR;
                end
                S_RD_LO:   if (!iic_busy) state_nxt = S_CHECK;
                S_CHECK:   state_nxt = (iic_rdata == val_q) ? S_NEXT : S_ERR;
`else
                S_WAIT_LO: if (!iic_busy) state_nxt = S_NEXT;
`endif
                S_NEXT:    state_nxt = idx_last ? S_DONE : S_FETCH;
                S_DONE,
                S_ERR:     if (cfg_restart) state_nxt = S_FETCH;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            dly_cnt   <= '0;
            tmo_cnt   <= '0;
            wdata_q   <= '0;
            tab_index <= '0;
        end else begin
            if (state == S_DLY && state_nxt == S_DLY) begin
                if (dly_cnt != {DLY_W{1'b1}}) dly_cnt <= dly_cnt + 1'b1;
            end else begin
                dly_cnt <= '0;
            end

`ifdef CFG_READBACK_EN
            if ((state == S_WAIT_HI || state == S_RD_HI) && state_nxt == state) begin
`else
            if (state == S_WAIT_HI && state_nxt == state) begin
`endif
                if (tmo_cnt != {TMO_W{1'b1}}) tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (iic_start) wdata_q <= iic_wdata;

            if (state_nxt == S_IDLE)
                tab_index <= '0;
            else if (state == S_NEXT && state_nxt == S_FETCH)
                tab_index <= tab_index + 1'b1;
            else if ((state == S_DONE || state == S_ERR) && state_nxt == S_FETCH)
                tab_index <= '0;
        end
    end

`ifdef CFG_READBACK_EN
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)                           val_q <= '0;
        else if (state == S_ISSUE && iic_start) val_q <= tab_data[7:0];
    end
`endif

    assign cfg_busy = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
    assign cfg_done = (state == S_DONE);
    assign cfg_err  = (state == S_ERR);

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Bench for ov5640_cfg_seq: ROM and IIC-master models, start/wdata scoreboard, scenario tasks.
module tb_ov5640_cfg_seq;
    localparam int         REG_NUM  = 3;
    localparam int         IDX_W    = 2;
    localparam int         DLY_CYC  = 10;
    localparam int         TMO_CYC  = 8;
    localparam int         BUSY_LEN = 20;
    localparam logic [7:0] DEV_ADDR = 8'h78;

    logic             sclk = 1'b0;
    logic             s_rst_n = 1'b0;
    logic             power_done = 1'b0;
    logic             cfg_restart = 1'b0;
    logic [IDX_W-1:0] tab_index;
    logic [23:0]      tab_data;
    logic             iic_start;
    logic [31:0]      iic_wdata;
    logic             iic_busy;
    logic [7:0]       iic_rdata = 8'h00;
    logic             cfg_busy, cfg_done, cfg_err;

    logic [23:0] rom [0:3];
    logic        no_busy = 1'b0;
    int          busy_left;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          start_cyc_q[$];

    ov5640_cfg_seq #(
        .REG_NUM(REG_NUM), .IDX_W(IDX_W), .DEV_ADDR(DEV_ADDR),
        .DLY_CYC(DLY_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .power_done(power_done), .cfg_restart(cfg_restart),
        .tab_index(tab_index), .tab_data(tab_data), .iic_start(iic_start), .iic_wdata(iic_wdata),
        .iic_busy(iic_busy), .iic_rdata(iic_rdata), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // Registered ROM: data follows the index by one cycle.
    always @(posedge sclk) tab_data <= rom[tab_index];

    // IIC master: busy for BUSY_LEN cycles starting the cycle after a start.
    always @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            iic_busy  <= 1'b0;
            busy_left <= 0;
        end else if (iic_start && !no_busy) begin
            iic_busy  <= 1'b1;
            busy_left <= BUSY_LEN;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) iic_busy <= 1'b0;
        end
    end

    // Scoreboard: every start pops one expected word.
    always @(negedge sclk) begin
        if (s_rst_n && iic_start) begin
            n_tests++;
            if (iic_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_while_busy: busy=%b at cycle %0d, required 0", iic_busy, cyc);
            end
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_start: wdata=%h at cycle %0d, no start expected", iic_wdata, cyc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (iic_wdata !== e) begin
                    n_fail++;
                    $display("FAIL start_wdata: got %h, required %h (cycle %0d)", iic_wdata, e, cyc);
                end
            end
            start_cyc_q.push_back(cyc);
        end
    end

    task automatic do_reset();
        s_rst_n = 1'b0; power_done = 1'b0; cfg_restart = 1'b0; no_busy = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        exp_q.delete();
        start_cyc_q.delete();
        s_rst_n = 1'b1;
    endtask

    task automatic power_up(output int n0);
        @(posedge sclk); #1;
        power_done = 1'b1;
        n0 = cyc;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        n_tests++; if (tab_index !== '0)   begin n_fail++; $display("FAIL rst_tab_index: got %h, required 0", tab_index); end
        n_tests++; if (iic_start !== 1'b0) begin n_fail++; $display("FAIL rst_iic_start: got %b, required 0", iic_start); end
        n_tests++; if (iic_wdata !== '0)   begin n_fail++; $display("FAIL rst_iic_wdata: got %h, required 0", iic_wdata); end
        n_tests++; if (cfg_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_cfg_busy: got %b, required 0", cfg_busy); end
        n_tests++; if (cfg_done !== 1'b0)  begin n_fail++; $display("FAIL rst_cfg_done: got %b, required 0", cfg_done); end
        n_tests++; if (cfg_err !== 1'b0)   begin n_fail++; $display("FAIL rst_cfg_err: got %b, required 0", cfg_err); end
        do_reset();
        repeat (5) @(negedge sclk);
        n_tests++; if (cfg_busy !== 1'b0 || start_cyc_q.size() != 0)
            begin n_fail++; $display("FAIL idle_without_power: busy=%b starts=%0d, required 0/0", cfg_busy, start_cyc_q.size()); end
    endtask

    task automatic test_write_seq();
        int n0, done_cyc;
        bit ok;
        do_reset();
        rom[0] = 24'h300A56; rom[1] = 24'h310311; rom[2] = 24'h300882; rom[3] = 24'hFFFFFF;
        exp_q.push_back(32'h78300A56);
        exp_q.push_back(32'h78310311);
        exp_q.push_back(32'h78300882);
        power_up(n0);
        ok = 0; done_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (cfg_done) begin ok = 1; done_cyc = cyc; break; end
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL write_done_timeout: cfg_done=%b, required 1", cfg_done); end
        n_tests++;
        if (start_cyc_q.size() != 3) begin
            n_fail++; $display("FAIL write_start_count: got %0d, required 3", start_cyc_q.size());
        end else begin
            n_tests++; if (start_cyc_q[0] != n0 + DLY_CYC + 2)
                begin n_fail++; $display("FAIL first_start_cycle: got %0d, required %0d", start_cyc_q[0], n0 + DLY_CYC + 2); end
            n_tests++; if (start_cyc_q[1] - start_cyc_q[0] != BUSY_LEN + 4)
                begin n_fail++; $display("FAIL entry_spacing: got %0d, required %0d", start_cyc_q[1] - start_cyc_q[0], BUSY_LEN + 4); end
            n_tests++; if (done_cyc != start_cyc_q[2] + BUSY_LEN + 3)
                begin n_fail++; $display("FAIL done_cycle: got %0d, required %0d", done_cyc, start_cyc_q[2] + BUSY_LEN + 3); end
        end
        n_tests++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL done_cfg_busy: got %b, required 0", cfg_busy); end
        n_tests++; if (tab_index !== 2'd2) begin n_fail++; $display("FAIL done_tab_index: got %0d, required 2", tab_index); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL write_missing_starts: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int n0, err_cyc, starts;
        bit ok;
        do_reset();
        no_busy = 1'b1;
        rom[0] = 24'h300A56;
        exp_q.push_back(32'h78300A56);
        power_up(n0);
        ok = 0; err_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sclk);
            if (cfg_err) begin ok = 1; err_cyc = cyc; break; end
        end
        n_tests++;
        if (!ok || start_cyc_q.size() != 1) begin
            n_fail++; $display("FAIL tmo_err: err=%b starts=%0d, required 1/1", cfg_err, start_cyc_q.size());
        end else begin
            n_tests++; if (err_cyc != start_cyc_q[0] + TMO_CYC + 1)
                begin n_fail++; $display("FAIL tmo_cycle: got %0d, required %0d", err_cyc, start_cyc_q[0] + TMO_CYC + 1); end
        end
        n_tests++; if (tab_index !== '0) begin n_fail++; $display("FAIL tmo_tab_index: got %0d, required 0", tab_index); end
        starts = start_cyc_q.size();
        repeat (30) @(negedge sclk);
        n_tests++; if (start_cyc_q.size() != starts || cfg_err !== 1'b1 || cfg_busy !== 1'b0)
            begin n_fail++; $display("FAIL tmo_hold: starts=%0d err=%b busy=%b, required %0d/1/0", start_cyc_q.size(), cfg_err, cfg_busy, starts); end
    endtask

    task automatic test_power_drop();
        int n0;
        bit ok;
        do_reset();
        rom[0] = 24'h300A56; rom[1] = 24'h310311; rom[2] = 24'h300882;
        exp_q.push_back({DEV_ADDR, rom[0]});
        exp_q.push_back({DEV_ADDR, rom[1]});
        power_up(n0);
        for (int i = 0; i < 200 && start_cyc_q.size() < 2; i++) @(negedge sclk);
        repeat (5) @(negedge sclk);
        @(posedge sclk); #1;
        power_done = 1'b0;
        @(negedge sclk);
        @(negedge sclk);
        n_tests++; if (cfg_busy !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0)
            begin n_fail++; $display("FAIL drop_flags: busy=%b done=%b err=%b, required 0/0/0", cfg_busy, cfg_done, cfg_err); end
        n_tests++; if (tab_index !== '0) begin n_fail++; $display("FAIL drop_tab_index: got %0d, required 0", tab_index); end
        repeat (25) @(negedge sclk);
        n_tests++; if (start_cyc_q.size() != 2 || exp_q.size() != 0)
            begin n_fail++; $display("FAIL drop_starts: got %0d starts, %0d pending, required 2/0", start_cyc_q.size(), exp_q.size()); end
        start_cyc_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({DEV_ADDR, rom[i]});
        power_up(n0);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (cfg_done) begin ok = 1; break; end
        end
        n_tests++; if (!ok || start_cyc_q.size() != 3 || exp_q.size() != 0)
            begin n_fail++; $display("FAIL repower_seq: done=%b starts=%0d, required 1/3", cfg_done, start_cyc_q.size()); end
        else begin
            n_tests++; if (start_cyc_q[0] != n0 + DLY_CYC + 2)
                begin n_fail++; $display("FAIL repower_first_start: got %0d, required %0d", start_cyc_q[0], n0 + DLY_CYC + 2); end
        end
    endtask

    task automatic test_restart();
        int r;
        bit ok;
        rom[0] = 24'h430030; rom[1] = 24'h3017FF; rom[2] = 24'h000000;
        start_cyc_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({DEV_ADDR, rom[i]});
        @(posedge sclk); #1;
        cfg_restart = 1'b1;
        r = cyc;
        @(posedge sclk); #1;
        cfg_restart = 1'b0;
        for (int i = 0; i < 50 && start_cyc_q.size() < 1; i++) @(negedge sclk);
        n_tests++;
        if (start_cyc_q.size() < 1) begin
            n_fail++; $display("FAIL restart_no_start: got 0 starts, required 1");
        end else if (start_cyc_q[0] != r + 2) begin
            n_fail++; $display("FAIL restart_latency: got %0d, required %0d", start_cyc_q[0], r + 2);
        end
        repeat (5) @(negedge sclk);
        @(posedge sclk); #1;
        n_tests++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy_pre: got %b, required 1", cfg_busy); end
        cfg_restart = 1'b1;
        @(posedge sclk); #1;
        cfg_restart = 1'b0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (cfg_done) begin ok = 1; break; end
        end
        n_tests++; if (!ok || start_cyc_q.size() != 3 || exp_q.size() != 0)
            begin n_fail++; $display("FAIL restart_seq: done=%b starts=%0d pending=%0d, required 1/3/0", cfg_done, start_cyc_q.size(), exp_q.size()); end
        n_tests++; if (tab_index !== 2'd2) begin n_fail++; $display("FAIL restart_tab_index: got %0d, required 2", tab_index); end
    endtask

    task automatic test_readback();
        int n0;
        bit ok;
        do_reset();
        rom[0] = 24'h300A56;
        iic_rdata = 8'h55;
        exp_q.push_back(32'h78300A56);
        exp_q.push_back(32'h79300A00);
        power_up(n0);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sclk);
            if (cfg_err) begin ok = 1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rb_err: got %b, required 1", cfg_err); end
        n_tests++; if (tab_index !== '0) begin n_fail++; $display("FAIL rb_tab_index: got %0d, required 0", tab_index); end
        n_tests++; if (start_cyc_q.size() != 2 || exp_q.size() != 0)
            begin n_fail++; $display("FAIL rb_starts: got %0d starts, %0d pending, required 2/0", start_cyc_q.size(), exp_q.size()); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = '0; rom[1] = '0; rom[2] = '0; rom[3] = '0;
        test_reset();
`ifdef CFG_READBACK_EN
        test_readback();
`else
        test_write_seq();
        test_timeout();
        test_power_drop();
        test_restart();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
